// File: rtl/pid_plant_pkg.sv
// Shared types, default configuration and helpers for the emulated plant.
package pid_plant_pkg;

  // Default plant configuration. The top module's parameters start from these values.
  localparam int PLANT_WIDTH = 8;
  localparam int PLANT_DIV   = 16;
  localparam int PLANT_SHIFT = 2;
  localparam int PLANT_DELAY = 4;

  // Accumulator width: it holds y * 2^SHIFT.
  localparam int ACC_W = PLANT_WIDTH + PLANT_SHIFT;

  // One entry of the transport-delay line, sized for the default width.
  typedef logic [PLANT_WIDTH-1:0] dl_entry_t;

  // Adds an unsigned y and a signed d, then clamps the result to [0, maxv].
  // The function works on ints so that it stays independent of the chosen width.
  function automatic int sat_add_u_s(input int y, input int d, input int maxv);
    int s;
    s = y + d;
    if (s < 0)         return 0;
    else if (s > maxv) return maxv;
    else               return s;
  endfunction

endpackage

// File: rtl/pid_plant_delay.sv
// Transport-delay shift register. Index 0 holds the newest entry and
// index DEPTH-1 the oldest. A fill writes one value into every entry.
module pid_plant_delay #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_shift,
  input  logic         i_fill,
  input  logic [W-1:0] i_fill_val,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_oldest
);

  logic [DEPTH-1:0][W-1:0] r_q;

  // A fill has priority over a shift, so a load overrides a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_fill) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= i_fill_val;
    end else if (i_shift) begin
      for (int i = DEPTH-1; i > 0; i--) r_q[i] <= r_q[i-1];
      r_q[0] <= i_din;
    end
  end

  assign o_oldest = r_q[DEPTH-1];

endmodule

// File: rtl/pid_plant_model.sv
// First-order plant with transport delay and an additive disturbance.
// It is the closed-loop partner of the PID controller.
module pid_plant_model
  import pid_plant_pkg::*;
#(
  parameter int WIDTH = PLANT_WIDTH,
  parameter int DIV   = PLANT_DIV,
  parameter int SHIFT = PLANT_SHIFT,
  parameter int DELAY = PLANT_DELAY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] u_in,
  input  logic [WIDTH-1:0] dist_in,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ack,
  output logic             sample_tick,
  output logic [WIDTH-1:0] y_out
);

  localparam int AW = WIDTH + SHIFT;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam int Y_MAX = (1 << WIDTH) - 1;

  logic [CW-1:0]    r_div;
  logic             r_tick;
  logic             r_ack;
  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] r_y;

  logic             w_tick;
  logic [WIDTH-1:0] w_ud;
  logic [WIDTH-1:0] w_y;
  logic [AW:0]      w_sum;
  logic [WIDTH-1:0] w_meas;

  // A tick is due when the last enabled count of the interval is reached.
  // A coincident load suppresses the tick.
  assign w_tick = ena & (r_div == DIV_LAST) & ~load_valid;
  assign w_y    = r_acc[AW-1:SHIFT];

  // Compute the update one bit wider than the accumulator. Because y_acc >= y,
  // the subtraction never goes below zero.
  assign w_sum  = {1'b0, r_acc}
                + {{(SHIFT+1){1'b0}}, w_ud}
                - {{(SHIFT+1){1'b0}}, w_y};

  assign w_meas = WIDTH'(sat_add_u_s(int'(w_y), int'($signed(dist_in)), Y_MAX));

  pid_plant_delay #(.W(WIDTH), .DEPTH(DELAY)) u_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_shift    (w_tick),
    .i_fill     (load_valid),
    .i_fill_val (load_value),
    .i_din      (u_in),
    .o_oldest   (w_ud)
  );

  // Sample divider, tick pulse and load acknowledge. A load restarts the interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
      r_ack  <= 1'b0;
    end else if (load_valid) begin
      r_div  <= '0;
      r_tick <= 1'b0;
      r_ack  <= 1'b1;
    end else begin
      r_ack  <= 1'b0;
      r_tick <= w_tick;
      if (ena) r_div <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    end
  end

  // Plant state: a forced load, or a first-order step on each tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_acc <= '0;
    else if (load_valid) r_acc <= {load_value, {SHIFT{1'b0}}};
    else if (w_tick)     r_acc <= w_sum[AW-1:0];
  end

  // Measurement register. It runs every cycle regardless of ena,
  // so the disturbance stays visible while the plant is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_y <= '0;
    else        r_y <= w_meas;
  end

  // The largest reachable value, (2^W-1)*2^S + 2^S - 1, is 2^AW - 1,
  // so the carry bit must stay clear.
  a_no_wrap: assert property (@(posedge clk) disable iff (!rst_n) w_tick |-> !w_sum[AW]);

  assign load_ack    = r_ack;
  assign sample_tick = r_tick;
  assign y_out       = r_y;

endmodule

// File: tb/tb_pid_plant_model.sv
module tb_pid_plant_model;
  import pid_plant_pkg::*;

  localparam int W  = 8;
  localparam int DV = 4;
  localparam int SH = 2;
  localparam int DL = 2;

  logic      clk = 1'b0;
  logic      rst_n, ena, load_valid;
  dl_entry_t u_in, dist_in, load_value;
  logic      load_ack, sample_tick;
  logic [W-1:0] y_out;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int m_div, m_acc, m_y, m_tick, m_ack, m_ticks;
  int dl_q[$];

  pid_plant_model #(.WIDTH(W), .DIV(DV), .SHIFT(SH), .DELAY(DL)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .u_in(u_in), .dist_in(dist_in),
    .load_valid(load_valid), .load_value(load_value), .load_ack(load_ack),
    .sample_tick(sample_tick), .y_out(y_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_div = 0; m_acc = 0; m_y = 0; m_tick = 0; m_ack = 0;
    dl_q = {};
    for (int i = 0; i < DL; i++) dl_q.push_back(0);
  endfunction

  // Apply one clock edge to the plant as the spec describes it,
  // then compare the DUT outputs 1 time unit after the edge.
  task automatic cyc();
    int yv, ud, sd;
    @(posedge clk);
    if (!rst_n) m_reset();
    else begin
      yv = m_acc / (1 << SH);
      sd = int'($signed(dist_in));
      m_y = yv + sd;
      if (m_y < 0) m_y = 0;
      if (m_y > 255) m_y = 255;
      if (load_valid) begin
        m_acc = int'(load_value) * (1 << SH);
        for (int i = 0; i < DL; i++) dl_q[i] = int'(load_value);
        m_div = 0; m_tick = 0; m_ack = 1;
      end else begin
        m_ack = 0; m_tick = 0;
        if (ena) begin
          if (m_div == DV - 1) begin
            m_div = 0; m_tick = 1; m_ticks++;
            ud = dl_q.pop_front();
            dl_q.push_back(int'(u_in));
            m_acc = m_acc + ud - yv;
          end else m_div++;
        end
      end
    end
    #1;
    chk("y_out", int'(y_out), m_y);
    chk("sample_tick", int'(sample_tick), m_tick);
    chk("load_ack", int'(load_ack), m_ack);
  endtask

  task automatic run_to_tick();
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!m_tick && n < 60);
    if (!m_tick) chk("tick_timeout", 0, 1);
  endtask

  initial begin
    int y0, n;
    rst_n = 0; ena = 0; u_in = 0; dist_in = 0; load_valid = 0; load_value = 0;
    m_ticks = 0;
    m_reset();
    #2;
    chk("rst_y", int'(y_out), 0);
    chk("rst_tick", int'(sample_tick), 0);
    chk("rst_ack", int'(load_ack), 0);
    repeat (2) cyc();
    rst_n = 1;

    // Step response to u = 200.
    ena = 1; u_in = 200;
    for (int k = 1; k <= 45; k++) begin
      run_to_tick();
      cyc();
      if (k <= 2)  chk("step_early", int'(y_out), 0);
      if (k == 3)  chk("step_t3", int'(y_out), 50);
      if (k == 4)  chk("step_t4", int'(y_out), 87);
      if (k == 5)  chk("step_t5", int'(y_out), 115);
      if (k == 45) chk("step_settled", int'(y_out), 200);
    end

    // Disturbance clamping.
    dist_in = 8'd100; cyc(); chk("dist_hi_clamp", int'(y_out), 255);
    dist_in = 8'd0;   cyc(); chk("dist_zero", int'(y_out), 200);
    load_valid = 1; load_value = 50; u_in = 50; cyc();
    load_valid = 0; cyc(); chk("load50", int'(y_out), 50);
    dist_in = 8'h80;  cyc(); chk("dist_lo_clamp", int'(y_out), 0);
    dist_in = 8'd0;   cyc(); chk("dist_back", int'(y_out), 50);

    // A load that coincides with a tick.
    n = 0;
    while (m_div != DV - 1 && n < 20) begin cyc(); n++; end
    load_valid = 1; load_value = 120; u_in = 120;
    cyc();
    chk("coinc_ack", int'(load_ack), 1);
    chk("coinc_tick", int'(sample_tick), 0);
    load_valid = 0;
    cyc(); chk("load120", int'(y_out), 120);
    for (int k = 0; k < 10; k++) begin
      run_to_tick();
      chk("hold120", int'(y_out), 120);
    end

    // Freezing the plant mid-interval.
    run_to_tick();
    cyc();
    y0 = int'(y_out);
    ena = 0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      chk("frz_tick", int'(sample_tick), 0);
      chk("frz_y", int'(y_out), y0);
    end
    ena = 1; n = 0;
    do begin cyc(); n++; end while (!sample_tick && n < 20);
    chk("resume_cnt", n, 3);

    // Asynchronous reset while y = 150.
    load_valid = 1; load_value = 150; u_in = 150; cyc();
    load_valid = 0;
    run_to_tick(); run_to_tick(); cyc();
    chk("pre_rst150", int'(y_out), 150);
    rst_n = 0; #1;
    chk("async_rst_y", int'(y_out), 0);
    m_reset();
    repeat (3) cyc();
    rst_n = 1;
    for (int k = 0; k < DL; k++) begin
      run_to_tick(); cyc();
      chk("post_rst_y", int'(y_out), 0);
    end

    // Randomised operation.
    m_ticks = 0; n = 0;
    while (m_ticks < 2000 && n < 40000) begin
      u_in       = 8'($urandom_range(0, 255));
      dist_in    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15) - 8);
      ena        = ($urandom_range(0, 9) != 0);
      load_valid = ($urandom_range(0, 299) == 0);
      load_value = 8'($urandom);
      cyc();
      n++;
    end
    load_valid = 0;
    chk("rand_ticks_reached", int'(m_ticks >= 2000), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
